// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding, the x0 register index,
// and the pause/flush control bundle with its canned settings.
package pipe_pkg;

  typedef enum logic [1:0] {
    StInit    = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2,
    StErr     = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bundle order, MSB first: PC, IF/ID, ID/EX, EX/MEM.
  typedef struct packed {
    logic pc_pause;
    logic ifid_pause;
    logic ifid_flush;
    logic idex_pause;
    logic idex_flush;
    logic exmem_pause;
  } ctrl_t;

  localparam ctrl_t CtrlNone   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CtrlFreeze = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CtrlFlush  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  // Hold PC and IF/ID, and push a bubble into ID/EX.
  localparam ctrl_t CtrlBubble = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: hazard/memory status in, stage controls out.
// With PIPE_PERF_CNT_EN defined the bundle also carries the performance counters.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_rs1_used_i;
  logic        id_rs2_used_i;
  logic [4:0]  ex_wR_i;
  logic        ex_rf_we_i;
  logic        ex_is_load_i;
  logic        ex_br_taken_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        pc_pause_o;
  logic        ifid_pause_o;
  logic        ifid_flush_o;
  logic        idex_pause_o;
  logic        idex_flush_o;
  logic        exmem_pause_o;
  logic        busy_o;
  logic        err_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cyc_o;
  logic [15:0] bubble_cnt_o;
  logic [15:0] flush_cnt_o;
`endif

  // Controller side.
  modport slave (
    input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_wR_i, ex_rf_we_i,
    input  ex_is_load_i, ex_br_taken_i, mem_req_i, mem_ack_i,
    output pc_pause_o, ifid_pause_o, ifid_flush_o, idex_pause_o, idex_flush_o,
    output exmem_pause_o, busy_o, err_o
`ifdef PIPE_PERF_CNT_EN
    , output stall_cyc_o, bubble_cnt_o, flush_cnt_o
`endif
  );

  // Pipeline side.
  modport master (
    output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, ex_wR_i, ex_rf_we_i,
    output ex_is_load_i, ex_br_taken_i, mem_req_i, mem_ack_i,
    input  pc_pause_o, ifid_pause_o, ifid_flush_o, idex_pause_o, idex_flush_o,
    input  exmem_pause_o, busy_o, err_o
`ifdef PIPE_PERF_CNT_EN
    , input stall_cyc_o, bubble_cnt_o, flush_cnt_o
`endif
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] ex_wr_i,
  input  logic       ex_rf_we_i,
  input  logic       ex_is_load_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;
  logic ex_load_wr;

  assign rs1_hit    = id_rs1_used_i && (id_rs1_i == ex_wr_i);
  assign rs2_hit    = id_rs2_used_i && (id_rs2_i == ex_wr_i);
  // x0 is hardwired, so a load targeting it never produces data worth waiting for.
  assign ex_load_wr = ex_is_load_i && ex_rf_we_i && (ex_wr_i != REG_ZERO);
  assign load_use_o = ex_load_wr && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pause/flush sequencer for the 5-stage pipeline: start-up flush, load-use bubbles, branch flushes
// and memory-wait freeze with timeout. Define PIPE_PERF_CNT_EN to add the performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntTimeout = CNT_W'(TIMEOUT_CYC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl;
  logic             busy;
  logic             err;
  logic             load_use;
  logic             stall_req;
  logic             ack_eff;

  hazard_detect u_hazard_detect (
    .id_rs1_i      (bus.id_rs1_i),
    .id_rs2_i      (bus.id_rs2_i),
    .id_rs1_used_i (bus.id_rs1_used_i),
    .id_rs2_used_i (bus.id_rs2_used_i),
    .ex_wr_i       (bus.ex_wR_i),
    .ex_rf_we_i    (bus.ex_rf_we_i),
    .ex_is_load_i  (bus.ex_is_load_i),
    .load_use_o    (load_use)
  );

  assign stall_req = bus.mem_req_i && !bus.mem_ack_i;
  // A request withdrawn while waiting ends the wait just like an ack.
  assign ack_eff   = bus.mem_ack_i || !bus.mem_req_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CtrlNone;
    busy    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      StInit: begin
        ctrl    = CtrlFlush;
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        if (stall_req) begin
          ctrl    = CtrlFreeze;
          state_d = StMemWait;
          cnt_d   = CntOne;
        end else if (bus.ex_br_taken_i) begin
          ctrl = CtrlFlush;
        end else if (load_use) begin
          ctrl = CtrlBubble;
        end
      end
      StMemWait: begin
        busy = 1'b1;
        if (ack_eff) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          ctrl = CtrlFreeze;
          if (cnt_q == CntTimeout) begin
            state_d = StErr;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end
      StErr: begin
        ctrl = CtrlFreeze;
        busy = 1'b1;
        err  = 1'b1;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_pause_o    = ctrl.pc_pause;
  assign bus.ifid_pause_o  = ctrl.ifid_pause;
  assign bus.ifid_flush_o  = ctrl.ifid_flush;
  assign bus.idex_pause_o  = ctrl.idex_pause;
  assign bus.idex_flush_o  = ctrl.idex_flush;
  assign bus.exmem_pause_o = ctrl.exmem_pause;
  assign bus.busy_o        = busy;
  assign bus.err_o         = err;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        in_run;

  assign in_run = (state_q == StRun);

  always_comb begin
    stall_cyc_d  = stall_cyc_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if ((in_run || (state_q == StMemWait)) && ctrl.pc_pause) begin
      stall_cyc_d = stall_cyc_q + 32'd1;
    end
    if (in_run && !stall_req && !bus.ex_br_taken_i && load_use) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
    if (in_run && !stall_req && bus.ex_br_taken_i) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cyc_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cyc_q  <= stall_cyc_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.stall_cyc_o  = stall_cyc_q;
  assign bus.bubble_cnt_o = bubble_cnt_q;
  assign bus.flush_cnt_o  = flush_cnt_q;
`endif

endmodule
